matrix_row_loader: RTL and testbench

Upstream feeder for the diagonal-skew timer stage. Accepts an N×N operand matrix one row per handshake over a valid/ready interface and stores it in a holding register array. Once the array is full, it launches one skew pass by holding the timer enable high for exactly 2N−1 cycles while the array stays frozen. It then pulses done and reopens for the next matrix.

---
 rtl/matrix_row_loader_if.sv | 9 +
 rtl/matrix_row_loader.sv | 74 +++++++
 tb/tb_matrix_row_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_loader_if.sv
// matrix_row_loader_if: row valid/ready handshake (row_valid, row_ready, row_data, row_last); master = upstream source, slave = loader
interface matrix_row_loader_if #(parameter int N = 32, parameter int W = 16);
  logic row_valid;
  logic row_ready;
  logic [0:N-1][W-1:0] row_data;
  logic row_last;
  modport master (output row_valid, row_data, row_last, input row_ready);
  modport slave (input row_valid, row_data, row_last, output row_ready);
endinterface

// File: rtl/matrix_row_loader.sv
// matrix_row_loader: loads an NxN matrix one row per handshake (clk, async rst, row slave port; outputs matrix_out, timer_en, busy, done, sticky err), then holds timer_en for 2N-1 cycles on a frozen matrix and pulses done; LOADER_TRANSPOSE_EN stores each row as a column
module matrix_row_loader #(
  parameter int N = 32,
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  matrix_row_loader_if.slave row,
  output logic [0:N-1][0:N-1][W-1:0] matrix_out,
  output logic timer_en,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam logic [RW-1:0] last_row = RW'(N - 1);
  localparam logic [FW-1:0] last_feed = FW'(2 * N - 2);
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  state_t state;
  logic [RW-1:0] row_cnt;
  logic [FW-1:0] feed_cnt;
  logic accept;
  assign row.row_ready = state == LOAD;
  assign accept = row.row_valid && row.row_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      row_cnt <= '0;
      feed_cnt <= '0;
      matrix_out <= '0;
      timer_en <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) begin
`ifdef LOADER_TRANSPOSE_EN
          for (int j = 0; j < N; j++) matrix_out[j][row_cnt] <= row.row_data[j];
`else
          matrix_out[row_cnt] <= row.row_data;
`endif
          busy <= 1'b1;
          if (row_cnt == last_row) begin
            row_cnt <= '0;
            feed_cnt <= '0;
            timer_en <= 1'b1;
            state <= RUN;
            if (!row.row_last) err <= 1'b1;
          end else if (row.row_last) begin
            row_cnt <= '0;
            err <= 1'b1;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
        RUN: if (feed_cnt == last_feed) begin
          feed_cnt <= '0;
          timer_en <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end else begin
          feed_cnt <= feed_cnt + FW'(1);
        end
        default: begin
          done <= 1'b0;
          state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_row_loader.sv
// tb_matrix_row_loader: self-checking bench for matrix_row_loader
module tb_matrix_row_loader;
  localparam int N = 32;
  localparam int W = 16;
  typedef logic [0:N-1][W-1:0] row_t;
  typedef struct {int r; int c; logic [W-1:0] v;} spot_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:N-1][0:N-1][W-1:0] matrix_out;
  logic timer_en, busy, done, err;
  logic [0:N-1][0:N-1][W-1:0] exp_m;
  logic model_err;
  int frame_pos;
  int vectors = 0;
  int miscompares = 0;
  spot_t spots[6];
  always #5 clk = ~clk;
  matrix_row_loader_if #(.N(N), .W(W)) bus ();
  matrix_row_loader #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .row(bus), .matrix_out(matrix_out),
    .timer_en(timer_en), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_mat(input string name);
    vectors++;
    if (matrix_out !== exp_m) begin
      miscompares++;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (matrix_out[r][c] !== exp_m[r][c]) begin
            $display("FAIL %s: matrix_out[%0d][%0d] got %0h expected %0h", name, r, c, matrix_out[r][c], exp_m[r][c]);
            return;
          end
    end
  endtask
  task automatic model_row(input row_t d, input logic last);
    for (int j = 0; j < N; j++)
`ifdef LOADER_TRANSPOSE_EN
      exp_m[j][frame_pos] = d[j];
`else
      exp_m[frame_pos][j] = d[j];
`endif
    if (frame_pos == N - 1) begin
      if (!last) model_err = 1'b1;
      frame_pos = 0;
    end else if (last) begin
      model_err = 1'b1;
      frame_pos = 0;
    end else begin
      frame_pos++;
    end
  endtask
  task automatic send_row(input row_t d, input logic last, output int waits);
    waits = 0;
    @(negedge clk);
    bus.row_valid = 1'b1;
    bus.row_data = d;
    bus.row_last = last;
    while (!bus.row_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.row_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    model_row(d, last);
  endtask
  function automatic row_t rand_row();
    row_t d;
    for (int j = 0; j < N; j++) d[j] = W'($urandom);
    return d;
  endfunction
  task automatic send_frame(input int base, input bit rnd, input bit with_last);
    row_t d;
    int w;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) d[j] = W'(base + N * k + j);
      if (rnd) d = rand_row();
      send_row(d, with_last && k == N - 1, w);
    end
  endtask
  task automatic check_run(input bit stall);
    int en_cnt = 0;
    bit stable = 1'b1;
    for (int c = 0; c < 2 * N - 1; c++) begin
      @(negedge clk);
      if (timer_en) en_cnt++;
      if (bus.row_ready || matrix_out !== exp_m) stable = 1'b0;
      if (c == 0) chk("run_busy", busy, 1);
      bus.row_valid = stall;
      bus.row_data = rand_row();
      bus.row_last = 1'($urandom);
    end
    chk("run_len", en_cnt, 2 * N - 1);
    chk("run_stable", stable, 1);
    @(negedge clk);
    bus.row_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_timer_en", timer_en, 0);
    chk("done_ready", bus.row_ready, 0);
    chk("done_busy", busy, 0);
    chk("done_err", err, model_err);
    chk_mat("done_matrix");
    @(negedge clk);
    chk("after_done_ready", bus.row_ready, 1);
    chk("after_done_pulse", done, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    row_t d;
    int w, en_seen, e, kind;
`ifdef LOADER_TRANSPOSE_EN
    spots = '{'{7, 5, 167}, '{5, 7, 229}, '{0, 0, 0}, '{31, 31, 1023}, '{0, 31, 992}, '{31, 0, 31}};
`else
    spots = '{'{5, 7, 167}, '{7, 5, 229}, '{0, 0, 0}, '{31, 31, 1023}, '{0, 31, 31}, '{31, 0, 992}};
`endif
    bus.row_valid = 1'b0;
    bus.row_data = '0;
    bus.row_last = 1'b0;
    exp_m = '0;
    model_err = 1'b0;
    frame_pos = 0;
    #2;
    chk("rst_timer_en", timer_en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk_mat("rst_matrix");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.row_ready, 1);
    send_frame(0, 0, 1);
    check_run(1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("nominal_spot_%0d_%0d", spots[i].r, spots[i].c), matrix_out[spots[i].r][spots[i].c], spots[i].v);
    chk("nominal_err", err, 0);
    for (int k = 0; k < 10; k++) begin
      d = rand_row();
      send_row(d, k == 9, w);
      if (k == 0) begin
        chk("next_frame_no_wait", w, 0);
        #1 chk("busy_first_row", busy, 1);
      end
    end
    en_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
      if (timer_en) en_seen++;
    end
    chk("early_no_run", en_seen, 0);
    chk("early_err", err, 1);
    chk("early_ready", bus.row_ready, 1);
    send_frame(2000, 0, 1);
    check_run(0);
    send_frame(0, 1, 0);
    check_run(1);
    send_frame(0, 0, 1);
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
    end
    chk("pre_rst_timer_en", timer_en, 1);
    rst = 1'b1;
    #1;
    exp_m = '0;
    model_err = 1'b0;
    frame_pos = 0;
    chk("midrun_rst_timer_en", timer_en, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_err", err, 0);
    chk_mat("midrun_rst_matrix");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_ready", bus.row_ready, 1);
    chk("midrun_rst_idle", timer_en, 0);
    for (int f = 0; f < 6; f++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        e = $urandom_range(0, N - 2);
        for (int k = 0; k <= e; k++) send_row(rand_row(), k == e, w);
        @(negedge clk);
        bus.row_valid = 1'b0;
        chk("rand_early_no_run", timer_en, 0);
        chk("rand_early_err", err, 1);
      end
      send_frame(0, 1, kind != 2);
      check_run(1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
